// File: rtl/bus_mem_responder.sv
// bus_mem_responder
//   Memory-side responder for the 64-bit tagged system bus. Serves one
//   line-sized transaction at a time from an internal word array:
//   reads return a BURST_LEN-beat burst after READ_LATENCY cycles, and
//   writes absorb a BURST_LEN-beat burst.
//
// Ports
//   clk          clock, rising-edge
//   reset        asynchronous, active-high
//   bus_reqcyc   request beat valid (address beat, then write-data beats)
//   bus_req      address / write-data beat
//   bus_reqtag   request tag, MSB = 1 read / 0 write (address beat only)
//   bus_reqack   responder accepts the current request beat
//   bus_respcyc  read-data beat valid
//   bus_resp     read-data beat
//   bus_resptag  echo of the captured request tag
//   bus_respack  initiator consumed the current response beat
module bus_mem_responder #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13,
  parameter int unsigned MEM_WORDS      = 4096,
  parameter int unsigned BURST_LEN      = 8,
  parameter int unsigned READ_LATENCY   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      bus_respack
);

  localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
  localparam int unsigned BEAT_W = $clog2(BURST_LEN);
  localparam int unsigned LINE_W = IDX_W - BEAT_W;
  // Byte offset within a line: beat index plus 8 bytes per 64-bit word.
  localparam int unsigned OFFS   = BEAT_W + 3;
  localparam int unsigned CNT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_RWAIT,
    S_RESP
  } state_t;

  state_t                    state_q;
  logic [LINE_W-1:0]         line_q;
  logic [BEAT_W-1:0]         beat_q;
  logic [BEAT_W-1:0]         beat_inc;
  logic [CNT_W-1:0]          cnt_q;
  logic                      last_beat;

  logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic                      mem_we;
  logic [IDX_W-1:0]          widx;
  logic [IDX_W-1:0]          ridx;

  always_comb begin
    beat_inc  = beat_q + BEAT_W'(1);
    last_beat = (beat_q == BEAT_W'(BURST_LEN - 1));
    mem_we    = (state_q == S_WDATA) && bus_reqcyc;
    widx      = {line_q, beat_q};
    // Read address looks one beat ahead so bus_resp is loaded with the
    // beat that becomes visible after the current edge.
    ridx      = (state_q == S_RESP) ? {line_q, beat_inc} : {line_q, {BEAT_W{1'b0}}};
  end

  // Array has no reset: contents persist across reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[widx] <= bus_req;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      bus_reqack  <= 1'b0;
      bus_respcyc <= 1'b0;
      bus_resp    <= '0;
      bus_resptag <= '0;
      line_q      <= '0;
      beat_q      <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus_reqcyc) begin
            state_q    <= S_ADDR;
            bus_reqack <= 1'b1;
          end
        end

        // Address is taken unconditionally here; the initiator holds
        // reqcyc until it sees the ack.
        S_ADDR: begin
          line_q      <= bus_req[OFFS +: LINE_W];
          bus_resptag <= bus_reqtag;
          beat_q      <= '0;
          if (bus_reqtag[BUS_TAG_WIDTH-1]) begin
            state_q    <= S_RWAIT;
            cnt_q      <= CNT_W'(READ_LATENCY - 1);
            bus_reqack <= 1'b0;
          end else begin
            state_q    <= S_WDATA;
          end
        end

        S_WDATA: begin
          if (bus_reqcyc) begin
            if (last_beat) begin
              state_q    <= S_IDLE;
              bus_reqack <= 1'b0;
              beat_q     <= '0;
            end else begin
              beat_q     <= beat_inc;
            end
          end
        end

        S_RWAIT: begin
          if (cnt_q == '0) begin
            state_q     <= S_RESP;
            bus_respcyc <= 1'b1;
            bus_resp    <= mem[ridx];
            beat_q      <= '0;
          end else begin
            cnt_q       <= cnt_q - CNT_W'(1);
          end
        end

        S_RESP: begin
          if (bus_respack) begin
            if (last_beat) begin
              state_q     <= S_IDLE;
              bus_respcyc <= 1'b0;
              beat_q      <= '0;
            end else begin
              beat_q      <= beat_inc;
              bus_resp    <= mem[ridx];
            end
          end
        end

        default: begin
          state_q     <= S_IDLE;
          bus_reqack  <= 1'b0;
          bus_respcyc <= 1'b0;
        end
      endcase
    end
  end

endmodule
